// File: rtl/fft_input_packer.sv
// Serial-to-parallel ping-pong packer feeding the full-parallel FFT core.
// Define BIT_REVERSE_EN to store each frame in bit-reversed order (decimation-in-time core).
module fft_input_packer #(
  parameter int NPOINT = 2,
  parameter int WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_valid,
  output logic                          din_busy,
  input  logic [WIDTH-1:0]              din_real,
  input  logic [WIDTH-1:0]              din_imag,
  input  logic                          din_clear,
  output logic                          dout_valid,
  input  logic                          dout_busy,
  output logic [WIDTH*(2**NPOINT)-1:0]  dout_real,
  output logic [WIDTH*(2**NPOINT)-1:0]  dout_imag
);

  localparam int N = 1 << NPOINT;

  logic [1:0]         r_full;
  logic               r_wrBank;
  logic               r_rdBank;
  logic [NPOINT-1:0]  r_wrIdx;
  logic [WIDTH*N-1:0] r_bankReal [2];
  logic [WIDTH*N-1:0] r_bankImag [2];

  logic [NPOINT-1:0]  w_pos;
  logic               w_inFire;
  logic               w_outFire;
  logic               w_lastBeat;

  assign din_busy   = r_full[r_wrBank] | din_clear;
  assign w_inFire   = din_valid & ~din_busy;
  assign dout_valid = r_full[r_rdBank];
  assign w_outFire  = dout_valid & ~dout_busy;
  assign w_lastBeat = (r_wrIdx == NPOINT'(N - 1));
  assign dout_real  = r_bankReal[r_rdBank];
  assign dout_imag  = r_bankImag[r_rdBank];

`ifdef BIT_REVERSE_EN
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < NPOINT; i++) begin
      w_pos[i] = r_wrIdx[NPOINT-1-i];
    end
  end
`else
  assign w_pos = r_wrIdx;
`endif

  // The fill and read sides touch different full flags, so a completing
  // frame and a departing frame in the same cycle never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= 2'b00;
      r_wrBank <= 1'b0;
      r_rdBank <= 1'b0;
      r_wrIdx  <= '0;
    end else begin
      if (w_outFire) begin
        r_full[r_rdBank] <= 1'b0;
        r_rdBank         <= ~r_rdBank;
      end
      if (din_clear) begin
        r_wrIdx <= '0;
      end else if (w_inFire) begin
        if (w_lastBeat) begin
          r_full[r_wrBank] <= 1'b1;
          r_wrBank         <= ~r_wrBank;
          r_wrIdx          <= '0;
        end else begin
          r_wrIdx <= r_wrIdx + NPOINT'(1);
        end
      end
    end
  end

  // Sample storage needs no reset; it is only observed once its bank is full.
  always_ff @(posedge clk) begin
    if (w_inFire) begin
      r_bankReal[r_wrBank][w_pos*WIDTH +: WIDTH] <= din_real;
      r_bankImag[r_wrBank][w_pos*WIDTH +: WIDTH] <= din_imag;
    end
  end

endmodule

// File: tb/tb_fft_input_packer.sv
// Directed self-checking bench for fft_input_packer (NPOINT=2, WIDTH=16).
// Honours BIT_REVERSE_EN when computing expected frame packing.
module tb_fft_input_packer;

  logic        clk;
  logic        rst_n;
  logic        din_valid;
  logic        din_busy;
  logic [15:0] din_real;
  logic [15:0] din_imag;
  logic        din_clear;
  logic        dout_valid;
  logic        dout_busy;
  logic [63:0] dout_real;
  logic [63:0] dout_imag;

  int total = 0;
  int bad   = 0;

  fft_input_packer #(.NPOINT(2), .WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din_busy   (din_busy),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .din_clear  (din_clear),
    .dout_valid (dout_valid),
    .dout_busy  (dout_busy),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected packed frame from four samples in arrival order.
  function automatic logic [63:0] packFrame(input logic [15:0] s0, input logic [15:0] s1,
                                            input logic [15:0] s2, input logic [15:0] s3);
`ifdef BIT_REVERSE_EN
    return {s3, s1, s2, s0};
`else
    return {s3, s2, s1, s0};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  // Drive one cycle's inputs just after the rising edge and let them settle.
  task automatic applyStimulus(input logic v, input logic [15:0] re, input logic [15:0] im,
                               input logic clr, input logic db);
    din_valid = v;
    din_real  = re;
    din_imag  = im;
    din_clear = clr;
    dout_busy = db;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [15:0] sRe [4];
  logic [15:0] sIm [4];
  logic        expValid;
  logic [63:0] expReal;
  logic [63:0] expImag;
  int          framesSeen;
  int          nextSample;
  int          accepted;

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);

    // Reset state, then idle.
    checkOutput("reset_din_busy", {63'd0, din_busy}, 64'd0);
    checkOutput("reset_dout_valid", {63'd0, dout_valid}, 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("idle_din_busy", {63'd0, din_busy}, 64'd0);
      checkOutput("idle_dout_valid", {63'd0, dout_valid}, 64'd0);
    end

    // Single frame 1..4 / -1..-4.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 16'(k + 1), 16'(-(k + 1)), 1'b0, 1'b0);
      checkOutput("single_din_busy", {63'd0, din_busy}, 64'd0);
      checkOutput("single_early_valid", {63'd0, dout_valid}, 64'd0);
      tick();
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("single_dout_valid", {63'd0, dout_valid}, 64'd1);
    checkOutput("single_dout_real", dout_real, packFrame(16'd1, 16'd2, 16'd3, 16'd4));
    checkOutput("single_dout_imag", dout_imag,
                packFrame(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC));
    tick();
    checkOutput("single_valid_drop", {63'd0, dout_valid}, 64'd0);

    // Backpressure: both banks fill, input stalls.
    doReset();
    nextSample = 1;
    accepted   = 0;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 16'(nextSample), 16'(nextSample + 256), 1'b0, 1'b1);
      if (!din_busy) begin
        accepted++;
        nextSample++;
      end
      tick();
    end
    checkOutput("bp_accepted", 64'(accepted), 64'd8);
    applyStimulus(1'b1, 16'(nextSample), 16'(nextSample + 256), 1'b0, 1'b1);
    checkOutput("bp_din_busy", {63'd0, din_busy}, 64'd1);
    checkOutput("bp_hold_valid", {63'd0, dout_valid}, 64'd1);
    checkOutput("bp_hold_real", dout_real, packFrame(16'd1, 16'd2, 16'd3, 16'd4));
    checkOutput("bp_hold_imag", dout_imag, packFrame(16'd257, 16'd258, 16'd259, 16'd260));
    tick();
    applyStimulus(1'b1, 16'd9, 16'd265, 1'b0, 1'b0);
    checkOutput("bp_release_busy", {63'd0, din_busy}, 64'd1);
    checkOutput("bp_release_real", dout_real, packFrame(16'd1, 16'd2, 16'd3, 16'd4));
    tick();
    applyStimulus(1'b1, 16'd9, 16'd265, 1'b0, 1'b1);
    checkOutput("bp_next_valid", {63'd0, dout_valid}, 64'd1);
    checkOutput("bp_next_real", dout_real, packFrame(16'd5, 16'd6, 16'd7, 16'd8));
    checkOutput("bp_next_din_busy", {63'd0, din_busy}, 64'd0);
    tick();
    applyStimulus(1'b1, 16'd10, 16'd266, 1'b0, 1'b1);
    checkOutput("bp_fill_din_busy", {63'd0, din_busy}, 64'd0);
    checkOutput("bp_fill_stable", dout_real, packFrame(16'd5, 16'd6, 16'd7, 16'd8));
    tick();

    // Clear discards a partial frame and blocks the sample offered with it.
    doReset();
    applyStimulus(1'b1, 16'd1, 16'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'd2, 16'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 16'd99, 16'd99, 1'b1, 1'b0);
    checkOutput("clr_din_busy", {63'd0, din_busy}, 64'd1);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 16'(k + 5), 16'(k + 50), 1'b0, 1'b0);
      checkOutput("clr_fill_busy", {63'd0, din_busy}, 64'd0);
      tick();
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("clr_dout_valid", {63'd0, dout_valid}, 64'd1);
    checkOutput("clr_dout_real", dout_real, packFrame(16'd5, 16'd6, 16'd7, 16'd8));
    checkOutput("clr_dout_imag", dout_imag, packFrame(16'd50, 16'd51, 16'd52, 16'd53));
    tick();
    checkOutput("clr_valid_drop", {63'd0, dout_valid}, 64'd0);

    // Streaming 64 random samples at full rate.
    doReset();
    expValid   = 1'b0;
    expReal    = '0;
    expImag    = '0;
    framesSeen = 0;
    for (int i = 0; i < 65; i++) begin
      if (i < 64) begin
        applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      end else begin
        applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      end
      checkOutput("stream_din_busy", {63'd0, din_busy}, 64'd0);
      checkOutput("stream_dout_valid", {63'd0, dout_valid}, {63'd0, expValid});
      if (expValid) begin
        checkOutput("stream_dout_real", dout_real, expReal);
        checkOutput("stream_dout_imag", dout_imag, expImag);
      end
      if (dout_valid) framesSeen++;
      expValid = 1'b0;
      if (i < 64) begin
        sRe[i%4] = din_real;
        sIm[i%4] = din_imag;
        if (i % 4 == 3) begin
          expValid = 1'b1;
          expReal  = packFrame(sRe[0], sRe[1], sRe[2], sRe[3]);
          expImag  = packFrame(sIm[0], sIm[1], sIm[2], sIm[3]);
        end
      end
      tick();
    end
    checkOutput("stream_frames", 64'(framesSeen), 64'd16);

    // Reset mid-frame with a frame pending.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 16'(k + 30), 16'(k + 30), 1'b0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b1);
    checkOutput("midrst_pending", {63'd0, dout_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_dout_valid", {63'd0, dout_valid}, 64'd0);
    checkOutput("midrst_din_busy", {63'd0, din_busy}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 16'(k + 21), 16'(k + 41), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    checkOutput("midrst_valid", {63'd0, dout_valid}, 64'd1);
    checkOutput("midrst_real", dout_real, packFrame(16'd21, 16'd22, 16'd23, 16'd24));
    checkOutput("midrst_imag", dout_imag, packFrame(16'd41, 16'd42, 16'd43, 16'd44));
    tick();
    checkOutput("midrst_valid_drop", {63'd0, dout_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
